xbar_write_data_scheduler: RTL and testbench

//  Sequences the W channel of one slave-side crossbar port. Records the source master and burst length of

---
 rtl/xbar_pkg.sv | 26 ++
 rtl/xbar_order_fifo.sv | 52 +++++
 rtl/xbar_write_data_scheduler.sv | 98 +++++++++
 tb/tb_xbar_write_data_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types: default port geometry, the W-order record and the
// beat-sequencer state encoding used by the write-data scheduler.
package xbar_pkg;

  localparam int XBAR_MASTERS       = 2;
  localparam int XBAR_LEN_WIDTH     = 4;
  localparam int XBAR_PENDING_DEPTH = 8;

  // Master-index width; a single master would still need one bit of select.
  function automatic int mw_of(input int masters);
    return (masters > 1) ? $clog2(masters) : 1;
  endfunction

  localparam int XBAR_MW = mw_of(XBAR_MASTERS);

  typedef struct packed {
    logic [XBAR_MW-1:0]        master;
    logic [XBAR_LEN_WIDTH-1:0] len;
  } w_order_t;

  typedef enum logic {
    BEAT_IDLE  = 1'b0,
    BEAT_BURST = 1'b1
  } beat_state_e;

endpackage

// File: rtl/xbar_order_fifo.sv
// Circular buffer of W-order records with wrap-bit pointers; full and empty are
// decoded from registered pointers only, so a same-cycle pop never frees a slot.
module xbar_order_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the queue is non-empty.
  always_ff @(posedge ACLK) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/xbar_write_data_scheduler.sv
// W-channel sequencer for one slave port: queues {master, len} per forwarded AW
// and routes W beats from those masters strictly in AW order.
module xbar_write_data_scheduler
  import xbar_pkg::*;
#(
  parameter int  masters       = XBAR_MASTERS,
  parameter int  LEN_WIDTH     = XBAR_LEN_WIDTH,
  parameter int  pending_depth = XBAR_PENDING_DEPTH,
  localparam int MW            = mw_of(masters),
  localparam int CW            = $clog2(pending_depth) + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_fire,
  input  logic [MW-1:0]        aw_src_master,
  input  logic [LEN_WIDTH-1:0] aw_len,
  output logic                 aw_block,
  output logic                 w_route_valid,
  output logic [MW-1:0]        w_src_master,
  input  logic                 w_fire,
  input  logic                 w_last,
  output logic [LEN_WIDTH-1:0] beat_cnt,
  output logic [CW-1:0]        outstanding,
  output logic                 last_err
);

  typedef struct packed {
    logic [MW-1:0]        master;
    logic [LEN_WIDTH-1:0] len;
  } order_t;

  order_t               push_rec;
  order_t               head_rec;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 w_accept;
  logic                 is_final;
  logic                 pop;
  logic                 err_set;
  logic [LEN_WIDTH-1:0] beat_cnt_d;
  beat_state_e          state_q;
  beat_state_e          state_d;

  assign push_rec = '{master: aw_src_master, len: aw_len};
  assign push_ok  = aw_fire & ~full;

  xbar_order_fifo #(
    .WIDTH ($bits(order_t)),
    .DEPTH (pending_depth)
  ) u_order_fifo (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .push      (aw_fire),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= BEAT_IDLE;
      beat_cnt <= '0;
      last_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
      if (err_set) last_err <= 1'b1;
    end
  end

  // BURST is held exactly while records are queued; a simultaneous push keeps it alive.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BEAT_IDLE:  if (push_ok) state_d = BEAT_BURST;
      BEAT_BURST: if (pop && (outstanding == CW'(1)) && !push_ok) state_d = BEAT_IDLE;
      default:    state_d = BEAT_IDLE;
    endcase
  end

  // Burst length decides the pop; WLAST is only audited against it.
  always_comb begin
    w_route_valid = ~empty;
    w_src_master  = empty ? '0 : head_rec.master;
    aw_block      = full;
    w_accept      = w_fire & ~empty;
    is_final      = (beat_cnt == head_rec.len);
    pop           = w_accept & is_final;
    err_set       = w_accept & (w_last != is_final);
    beat_cnt_d    = beat_cnt;
    if (w_accept) beat_cnt_d = is_final ? '0 : beat_cnt + LEN_WIDTH'(1);
  end

endmodule

// File: tb/tb_xbar_write_data_scheduler.sv
// Directed bench for the write-data scheduler: ordering, full/wrap, WLAST audit,
// push latency and asynchronous reset mid-burst, with hand-computed expectations.
module tb_xbar_write_data_scheduler;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       aw_fire;
  logic [0:0] aw_src_master;
  logic [3:0] aw_len;
  logic       aw_block;
  logic       w_route_valid;
  logic [0:0] w_src_master;
  logic       w_fire;
  logic       w_last;
  logic [3:0] beat_cnt;
  logic [3:0] outstanding;
  logic       last_err;

  int checks = 0;
  int errors = 0;

  xbar_write_data_scheduler #(
    .masters       (2),
    .LEN_WIDTH     (4),
    .pending_depth (8)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .aw_fire       (aw_fire),
    .aw_src_master (aw_src_master),
    .aw_len        (aw_len),
    .aw_block      (aw_block),
    .w_route_valid (w_route_valid),
    .w_src_master  (w_src_master),
    .w_fire        (w_fire),
    .w_last        (w_last),
    .beat_cnt      (beat_cnt),
    .outstanding   (outstanding),
    .last_err      (last_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, then returns idle inputs.
  task automatic applyStimulus(input logic aw, input int m, input int len, input logic wf, input logic wl);
    aw_fire       = aw;
    aw_src_master = m[0:0];
    aw_len        = len[3:0];
    w_fire        = wf;
    w_last        = wl;
    @(posedge ACLK);
    #1;
    aw_fire = 1'b0;
    w_fire  = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " aw_block"},    32'(aw_block),      0);
    checkOutput({tag, " route_valid"}, 32'(w_route_valid), 0);
    checkOutput({tag, " src_master"},  32'(w_src_master),  0);
    checkOutput({tag, " beat_cnt"},    32'(beat_cnt),      0);
    checkOutput({tag, " outstanding"}, 32'(outstanding),   0);
    checkOutput({tag, " last_err"},    32'(last_err),      0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_drain [7] = '{0, 1, 0, 1, 0, 1, 1};

    ARESETn       = 1'b0;
    aw_fire       = 1'b0;
    aw_src_master = '0;
    aw_len        = '0;
    w_fire        = 1'b0;
    w_last        = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checkIdle("reset");
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    $display("[TB] order: m1 len=1 then m0 len=0");
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("order out#1", 32'(outstanding), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("order out#2", 32'(outstanding), 2);
    checkOutput("order src beat0", 32'(w_src_master), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("order out#3", 32'(outstanding), 2);
    checkOutput("order src beat1", 32'(w_src_master), 1);
    checkOutput("order beat_cnt", 32'(beat_cnt), 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("order out#4", 32'(outstanding), 1);
    checkOutput("order src m0", 32'(w_src_master), 0);
    checkOutput("order valid m0", 32'(w_route_valid), 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("order out#5", 32'(outstanding), 0);
    checkOutput("order valid end", 32'(w_route_valid), 0);
    checkOutput("order last_err", 32'(last_err), 0);

    $display("[TB] full: eight AWs without W");
    for (int i = 0; i < 8; i++) begin
      checkOutput("full block early", 32'(aw_block), 0);
      applyStimulus(1, i % 2, 0, 0, 0);
      checkOutput("full fill count", 32'(outstanding), 32'(i + 1));
    end
    checkOutput("full aw_block", 32'(aw_block), 1);
    applyStimulus(1, 1, 0, 1, 1);
    checkOutput("full push dropped", 32'(outstanding), 7);
    checkOutput("full unblock", 32'(aw_block), 0);
    applyStimulus(1, 1, 0, 1, 1);
    checkOutput("full push+pop", 32'(outstanding), 7);
    checkOutput("full push+pop block", 32'(aw_block), 0);
    for (int i = 0; i < 7; i++) begin
      checkOutput("full drain src", 32'(w_src_master), 32'(exp_drain[i]));
      applyStimulus(0, 0, 0, 1, 1);
    end
    checkOutput("full drained", 32'(outstanding), 0);

    $display("[TB] wrap: twenty overlapped single-beat bursts");
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 1; k < 20; k++) begin
      checkOutput("wrap src", 32'(w_src_master), 32'((k - 1) % 2));
      applyStimulus(1, k % 2, 0, 1, 1);
      checkOutput("wrap count", 32'(outstanding), 1);
    end
    checkOutput("wrap src tail", 32'(w_src_master), 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wrap empty", 32'(outstanding), 0);
    checkOutput("wrap valid", 32'(w_route_valid), 0);
    checkOutput("wrap last_err", 32'(last_err), 0);

    $display("[TB] errors: premature WLAST on len=2");
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("early beat_cnt", 32'(beat_cnt), 1);
    checkOutput("early no err yet", 32'(last_err), 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("early last_err", 32'(last_err), 1);
    checkOutput("early no pop", 32'(outstanding), 1);
    checkOutput("early beat_cnt2", 32'(beat_cnt), 2);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("early third pops", 32'(outstanding), 0);
    checkOutput("early beat_cnt0", 32'(beat_cnt), 0);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("midrst beat_cnt", 32'(beat_cnt), 2);
    checkOutput("midrst src", 32'(w_src_master), 1);
    #2;
    ARESETn = 1'b0;
    #1;
    checkIdle("midrst");
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    $display("[TB] latency: AW into empty queue with simultaneous W");
    aw_fire       = 1'b1;
    aw_src_master = 1'b1;
    aw_len        = 4'd0;
    w_fire        = 1'b1;
    w_last        = 1'b1;
    #1;
    checkOutput("lat valid at N", 32'(w_route_valid), 0);
    @(posedge ACLK);
    #1;
    aw_fire = 1'b0;
    w_fire  = 1'b0;
    w_last  = 1'b0;
    checkOutput("lat valid at N+1", 32'(w_route_valid), 1);
    checkOutput("lat src", 32'(w_src_master), 1);
    checkOutput("lat ignored W", 32'(outstanding), 1);
    checkOutput("lat no err", 32'(last_err), 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("lat drained", 32'(outstanding), 0);

    $display("[TB] errors: missing WLAST on len=1");
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("miss no err yet", 32'(last_err), 0);
    checkOutput("miss held", 32'(outstanding), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("miss pops", 32'(outstanding), 0);
    checkOutput("miss last_err", 32'(last_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
